demux_1to8_1bit_seq: RTL and testbench

Receive-side counterpart of the 8-to-1 dual-rail-select mux. It takes a serial lane that a transmitter drives by stepping its 8:1 mux through slots 0..7, and reassembles the slots into eight parallel outputs Out0..Out7. It generates the slot index as a dual-rail Select/_Select pair, so the same counter value can drive a matching mux at the far end. A completed frame is presented with a Valid/Ack handshake.

---
 rtl/demux_1to8_1bit_seq.sv | 108 ++++++++++
 tb/tb_demux_1to8_1bit_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/demux_1to8_1bit_seq.sv
// Serial-to-parallel 1:8 demux: steps a dual-rail slot index, stages slots 0..6,
// presents a full frame on Out0..Out7 with a Valid/Ack handshake. Optional: OVERRUN_FLAG_EN.
module demux_1to8_1bit_seq #(
   parameter int DATA_W = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] In,
   input  logic              Enable,
   input  logic              Clear,
   input  logic              Ack,
   output logic [2:0]        Select,
   output logic [2:0]        _Select,
   output logic              Ready,
   output logic [DATA_W-1:0] Out0,
   output logic [DATA_W-1:0] Out1,
   output logic [DATA_W-1:0] Out2,
   output logic [DATA_W-1:0] Out3,
   output logic [DATA_W-1:0] Out4,
   output logic [DATA_W-1:0] Out5,
   output logic [DATA_W-1:0] Out6,
   output logic [DATA_W-1:0] Out7,
`ifdef OVERRUN_FLAG_EN
   output logic              Overrun,
`endif
   output logic              Valid
);

   logic [2:0]             sel_q, sel_d;
   logic [2:0]             nsel_q, nsel_d;
   logic [7:0][DATA_W-1:0] stg_q, stg_d;
   logic [7:0][DATA_W-1:0] out_q, out_d;
   logic                   valid_q, valid_d;
   logic                   ready, accept, complete;

   // Only a held, unacknowledged frame with slot 7 pending can stall the lane.
   assign ready    = !(valid_q && sel_q == 3'd7);
   assign accept   = Enable && ready && !Clear;
   assign complete = accept && sel_q == 3'd7;

   always_comb begin
      sel_d   = sel_q;
      stg_d   = stg_q;
      out_d   = out_q;
      valid_d = valid_q;
      if (Clear) begin
         sel_d = 3'd0;
      end else if (accept) begin
         stg_d[sel_q] = In;
         sel_d        = sel_q + 3'd1;
      end
      // Complement rail is registered from the same next value, so it never glitches apart.
      nsel_d = ~sel_d;
      if (complete) begin
         out_d   = {In, stg_q[6:0]};
         valid_d = 1'b1;
      end else if (valid_q && Ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sel_q   <= 3'd0;
         nsel_q  <= 3'd7;
         stg_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         nsel_q  <= nsel_d;
         stg_q   <= stg_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

`ifdef OVERRUN_FLAG_EN
   logic ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (Clear)                 ovr_d = 1'b0;
      else if (Enable && !ready) ovr_d = 1'b1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) ovr_q <= 1'b0;
      else       ovr_q <= ovr_d;
   end

   assign Overrun = ovr_q;
`endif

   assign Select  = sel_q;
   assign _Select = nsel_q;
   assign Ready   = ready;
   assign Valid   = valid_q;
   assign Out0    = out_q[0];
   assign Out1    = out_q[1];
   assign Out2    = out_q[2];
   assign Out3    = out_q[3];
   assign Out4    = out_q[4];
   assign Out5    = out_q[5];
   assign Out6    = out_q[6];
   assign Out7    = out_q[7];

endmodule

// File: tb/tb_demux_1to8_1bit_seq.sv
// Directed vector table plus async-reset and randomized scoreboard runs for the 1:8 demux.
module tb_demux_1to8_1bit_seq;

   logic Clock = 1'b0;
   logic Reset;
   logic en, clr, ack, din;
   logic [3:0] din4;
   logic [2:0] sel, nsel, sel4, nsel4;
   logic rdy, vld, rdy4, vld4;
   logic [7:0] ob;
   logic [7:0][3:0] o4;
`ifdef OVERRUN_FLAG_EN
   logic ovr, ovr4;
`endif

   always #5 Clock = ~Clock;

   demux_1to8_1bit_seq #(.DATA_W(1)) u_dut (
      .Clock(Clock), .Reset(Reset), .In(din), .Enable(en), .Clear(clr), .Ack(ack),
      .Select(sel), ._Select(nsel), .Ready(rdy),
      .Out0(ob[0]), .Out1(ob[1]), .Out2(ob[2]), .Out3(ob[3]),
      .Out4(ob[4]), .Out5(ob[5]), .Out6(ob[6]), .Out7(ob[7]),
`ifdef OVERRUN_FLAG_EN
      .Overrun(ovr),
`endif
      .Valid(vld)
   );

   demux_1to8_1bit_seq #(.DATA_W(4)) u_dut4 (
      .Clock(Clock), .Reset(Reset), .In(din4), .Enable(en), .Clear(clr), .Ack(ack),
      .Select(sel4), ._Select(nsel4), .Ready(rdy4),
      .Out0(o4[0]), .Out1(o4[1]), .Out2(o4[2]), .Out3(o4[3]),
      .Out4(o4[4]), .Out5(o4[5]), .Out6(o4[6]), .Out7(o4[7]),
`ifdef OVERRUN_FLAG_EN
      .Overrun(ovr4),
`endif
      .Valid(vld4)
   );

   typedef struct {
      logic en, clr, ack, din;
      logic [2:0] sel;
      logic vld, rdy, ovr;
      logic [7:0] out;
   } vec_t;

   vec_t tbl[$];
   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic e, c, a, d, input logic [2:0] s,
                               input logic v, r, o, input logic [7:0] ob_exp);
      vec_t t;
      t.en = e; t.clr = c; t.ack = a; t.din = d;
      t.sel = s; t.vld = v; t.rdy = r; t.ovr = o; t.out = ob_exp;
      tbl.push_back(t);
   endfunction

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   logic [7:0] b;
   logic [2:0] m_sel;
   logic [7:0][3:0] m_stg, m_out;
   logic m_vld, m_rdy, m_acc;
   logic [7:0] m_ob;

   initial begin
      Reset = 1'b1; en = 0; clr = 0; ack = 0; din = 0; din4 = 0;
      // frame 1: 1,0,1,1,0,0,1,0 -> 8'h4D
      b = 8'h4D;
      for (int k = 0; k < 8; k++) add(1, 0, 0, b[k], 3'(k + 1), k == 7, 1, 0, (k == 7) ? 8'h4D : 8'h00);
      // back-to-back with Ack high
      b = 8'hA5;
      for (int k = 0; k < 8; k++) add(1, 0, 1, b[k], 3'(k + 1), k == 7, 1, 0, (k == 7) ? 8'hA5 : 8'h4D);
      b = 8'h3C;
      for (int k = 0; k < 8; k++) add(1, 0, 1, b[k], 3'(k + 1), k == 7, 1, 0, (k == 7) ? 8'h3C : 8'hA5);
      // backpressure: Ack low, slot 7 stalls
      b = 8'h81;
      for (int k = 0; k < 7; k++) add(1, 0, 0, b[k], 3'(k + 1), 1, k != 6, 0, 8'h3C);
      for (int r = 0; r < 3; r++) add(1, 0, 0, 1, 3'd7, 1, 0, 1, 8'h3C);
      add(1, 0, 1, 1, 3'd7, 0, 1, 1, 8'h3C);
      add(1, 0, 0, 1, 3'd0, 1, 1, 1, 8'h81);
      // three slots then Clear with Enable
      for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 3'(k + 1), 0, 1, 1, 8'h81);
      add(1, 1, 0, 1, 3'd0, 0, 1, 0, 8'h81);
      for (int k = 0; k < 8; k++) add(1, 0, 0, 1, 3'(k + 1), k == 7, 1, 0, (k == 7) ? 8'hFF : 8'h81);

      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      chk("reset", {sel, nsel, vld, rdy, ob}, {3'd0, 3'd7, 1'b0, 1'b1, 8'h00});
      chk("reset4", {sel4, nsel4, vld4, rdy4, o4}, {3'd0, 3'd7, 1'b0, 1'b1, 32'h0});

      foreach (tbl[i]) begin
         en = tbl[i].en; clr = tbl[i].clr; ack = tbl[i].ack; din = tbl[i].din; din4 = {4{tbl[i].din}};
         step();
         chk($sformatf("vec%0d", i), {sel, nsel, vld, rdy, ob},
             {tbl[i].sel, ~tbl[i].sel, tbl[i].vld, tbl[i].rdy, tbl[i].out});
`ifdef OVERRUN_FLAG_EN
         chk($sformatf("ovr%0d", i), ovr, tbl[i].ovr);
`endif
      end

      // async reset mid-frame, between edges
      en = 1; ack = 0; clr = 0; din = 1; din4 = 4'hF;
      for (int k = 0; k < 5; k++) step();
      chk("pre_rst", {sel, vld}, {3'd5, 1'b1});
      en = 0;
      #2 Reset = 1'b1;
      #1 chk("async_rst", {sel, nsel, vld, rdy, ob}, {3'd0, 3'd7, 1'b0, 1'b1, 8'h00});
      @(negedge Clock);
      Reset = 1'b0;
      b = 8'h96;
      for (int k = 0; k < 8; k++) begin
         en = 1; din = b[k]; din4 = {4{b[k]}};
         step();
      end
      chk("post_rst", {sel, nsel, vld, rdy, ob}, {3'd0, 3'd7, 1'b1, 1'b1, 8'h96});

      // randomized run against a behavioural scoreboard, both widths
      en = 0; clr = 0; ack = 0;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      m_sel = 0; m_stg = '0; m_out = '0; m_vld = 0;
      for (int c = 0; c < 10000; c++) begin
         en   = ($urandom_range(0, 9) < 7);
         ack  = ($urandom_range(0, 9) < 3);
         clr  = ($urandom_range(0, 99) < 3);
         din4 = 4'($urandom);
         din  = din4[0];
         m_rdy = !(m_vld && m_sel == 3'd7);
         m_acc = en && m_rdy && !clr;
         @(posedge Clock);
         if (m_acc && m_sel == 3'd7) begin
            m_out = {din4, m_stg[6:0]};
            m_vld = 1'b1;
         end else if (m_vld && ack) begin
            m_vld = 1'b0;
         end
         if (clr) m_sel = 3'd0;
         else if (m_acc) begin
            m_stg[m_sel] = din4;
            m_sel = m_sel + 3'd1;
         end
         @(negedge Clock);
         m_rdy = !(m_vld && m_sel == 3'd7);
         for (int k = 0; k < 8; k++) m_ob[k] = m_out[k][0];
         chk("rail", {sel ^ nsel, sel4 ^ nsel4}, 6'h3F);
         chk("rand", {sel4, vld4, rdy4, o4, sel, vld, rdy, ob},
             {m_sel, m_vld, m_rdy, m_out, m_sel, m_vld, m_rdy, m_ob});
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
